// File: rtl/qspi_pkg.sv
// Shared QSPI controller definitions: lane-mode encodings, rx state encoding
// and the bits-per-sample helper.
package qspi_pkg;

  typedef enum logic [1:0] {
    LANE_SINGLE  = 2'b00,
    LANE_DUAL    = 2'b01,
    LANE_QUAD    = 2'b10,
    LANE_ILLEGAL = 2'b11
  } lane_mode_e;

  typedef enum logic [1:0] {
    RX_IDLE    = 2'd0,
    RX_DUMMY   = 2'd1,
    RX_SHIFT   = 2'd2,
    RX_HANDOFF = 2'd3
  } rx_state_e;

  // An illegal mode yields 0; callers reject that mode before it is latched.
  function automatic logic [2:0] bits_per_sample(input logic [1:0] mode);
    case (mode)
      LANE_SINGLE: bits_per_sample = 3'd1;
      LANE_DUAL:   bits_per_sample = 3'd2;
      LANE_QUAD:   bits_per_sample = 3'd4;
      default:     bits_per_sample = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/qspi_rx_shifter_if.sv
// Control, sample and read-handshake signals of the QSPI receive shifter.
// master: the controller/sink side; slave: the shifter itself.
interface qspi_rx_shifter_if #(
  parameter int DATA_BITS = 32,
  parameter int DUMMY_W   = 5,
  parameter int WORDS_W   = 8
);
  logic                 start;
  logic                 abort;
  logic [1:0]           lane_mode;
  logic [DUMMY_W-1:0]   dummy_cycles;
  logic [WORDS_W-1:0]   num_words;
  logic                 sample_en;
  logic [3:0]           io_in;
  logic                 sink_valid;
  logic [DATA_BITS-1:0] data_out;
  logic                 word_ready;
  logic                 sclk_hold;
  logic                 busy;
  logic                 done;
  logic                 err;

  modport master (
    output start, abort, lane_mode, dummy_cycles, num_words, sample_en, io_in, sink_valid,
    input  data_out, word_ready, sclk_hold, busy, done, err
  );

  modport slave (
    input  start, abort, lane_mode, dummy_cycles, num_words, sample_en, io_in, sink_valid,
    output data_out, word_ready, sclk_hold, busy, done, err
  );

endinterface

// File: rtl/qspi_rx_lane_mux.sv
// Selects the active IO lanes for the latched lane mode, right-justified with
// the highest-numbered IO as the sample MSB, and reports bits per sample.
module qspi_rx_lane_mux
  import qspi_pkg::*;
(
  input  logic [1:0] i_lane_mode,
  input  logic [3:0] i_io,
  output logic [3:0] o_sample,
  output logic [2:0] o_bpw
);

  always_comb begin
    o_sample = 4'b0000;
    case (i_lane_mode)
      LANE_SINGLE: o_sample = {3'b000, i_io[1]};
      LANE_DUAL:   o_sample = {2'b00, i_io[1:0]};
      default:     o_sample = i_io;
    endcase
  end

  assign o_bpw = bits_per_sample(i_lane_mode);

endmodule

// File: rtl/qspi_rx_shifter.sv
// QSPI receive shifter: dummy skip, MSB-first word assembly, stalled handoff.
// Build option QSPI_RX_BYTE_SWAP_EN byte-reverses each completed word.
module qspi_rx_shifter
  import qspi_pkg::*;
#(
  parameter int DATA_BITS = 32,
  parameter int DUMMY_W   = 5,
  parameter int WORDS_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  qspi_rx_shifter_if.slave bus
);

  localparam int CNT_W = $clog2(DATA_BITS);

  rx_state_e            r_state;
  rx_state_e            w_next_state;
  lane_mode_e           r_lane_mode;
  logic [DUMMY_W-1:0]   r_dummy;
  logic [WORDS_W-1:0]   r_words;
  logic [CNT_W-1:0]     r_samp_cnt;
  logic [DATA_BITS-1:0] r_shreg;
  logic [DATA_BITS-1:0] r_data_out;
  logic                 r_done;
  logic                 r_err;

  logic [3:0]           w_sample;
  logic [2:0]           w_bpw;
  logic [DATA_BITS-1:0] w_shift_next;
  logic [DATA_BITS-1:0] w_word_out;
  logic                 w_samp_last;
  logic                 w_start_legal;
  logic                 w_start_ok;
  logic                 w_start_bad;
  logic                 w_handoff;
  logic                 w_done_set;

  function automatic logic [DATA_BITS-1:0] byte_swap(input logic [DATA_BITS-1:0] w);
    logic [DATA_BITS-1:0] r;
    r = '0;
    for (int b = 0; b < DATA_BITS / 8; b++)
      r[8*b +: 8] = w[DATA_BITS-8-8*b +: 8];
    return r;
  endfunction

  qspi_rx_lane_mux u_lane_mux (
    .i_lane_mode (r_lane_mode),
    .i_io        (bus.io_in),
    .o_sample    (w_sample),
    .o_bpw       (w_bpw)
  );

  always_comb begin
    w_shift_next = r_shreg;
    case (w_bpw)
      3'd1:    w_shift_next = {r_shreg[DATA_BITS-2:0], w_sample[0]};
      3'd2:    w_shift_next = {r_shreg[DATA_BITS-3:0], w_sample[1:0]};
      default: w_shift_next = {r_shreg[DATA_BITS-5:0], w_sample};
    endcase
  end

`ifdef QSPI_RX_BYTE_SWAP_EN
  assign w_word_out = byte_swap(w_shift_next);
`else
  assign w_word_out = w_shift_next;
`endif

  always_comb begin
    w_samp_last = 1'b0;
    case (r_lane_mode)
      LANE_SINGLE: w_samp_last = (r_samp_cnt == CNT_W'(DATA_BITS - 1));
      LANE_DUAL:   w_samp_last = (r_samp_cnt == CNT_W'(DATA_BITS / 2 - 1));
      default:     w_samp_last = (r_samp_cnt == CNT_W'(DATA_BITS / 4 - 1));
    endcase
  end

  assign w_start_legal = (bus.lane_mode != LANE_ILLEGAL) && (bus.num_words != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= RX_IDLE;
    else       r_state <= w_next_state;
  end

  // Abort outranks everything, including a start or a handoff on the same edge.
  always_comb begin
    w_next_state = r_state;
    w_start_ok   = 1'b0;
    w_start_bad  = 1'b0;
    w_handoff    = 1'b0;
    w_done_set   = 1'b0;
    if (bus.abort) begin
      w_next_state = RX_IDLE;
    end else begin
      case (r_state)
        RX_IDLE: begin
          if (bus.start) begin
            if (w_start_legal) begin
              w_start_ok   = 1'b1;
              w_next_state = (bus.dummy_cycles != '0) ? RX_DUMMY : RX_SHIFT;
            end else begin
              w_start_bad  = 1'b1;
            end
          end
        end
        RX_DUMMY: begin
          if (bus.sample_en && r_dummy == DUMMY_W'(1)) w_next_state = RX_SHIFT;
        end
        RX_SHIFT: begin
          if (bus.sample_en && w_samp_last) w_next_state = RX_HANDOFF;
        end
        RX_HANDOFF: begin
          if (!bus.sink_valid) begin
            w_handoff = 1'b1;
            if (r_words == WORDS_W'(1)) begin
              w_next_state = RX_IDLE;
              w_done_set   = 1'b1;
            end else begin
              w_next_state = RX_SHIFT;
            end
          end
        end
        default: w_next_state = RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lane_mode <= LANE_SINGLE;
      r_dummy     <= '0;
      r_words     <= '0;
      r_samp_cnt  <= '0;
      r_data_out  <= '0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_done <= w_done_set;
      r_err  <= w_start_bad;
      if (bus.abort) begin
        r_dummy    <= '0;
        r_words    <= '0;
        r_samp_cnt <= '0;
      end else begin
        if (w_start_ok) begin
          r_lane_mode <= lane_mode_e'(bus.lane_mode);
          r_dummy     <= bus.dummy_cycles;
          r_words     <= bus.num_words;
          r_samp_cnt  <= '0;
        end
        if (r_state == RX_DUMMY && bus.sample_en) r_dummy <= r_dummy - DUMMY_W'(1);
        if (r_state == RX_SHIFT && bus.sample_en) begin
          r_samp_cnt <= w_samp_last ? '0 : r_samp_cnt + CNT_W'(1);
          if (w_samp_last) r_data_out <= w_word_out;
        end
        if (w_handoff) r_words <= r_words - WORDS_W'(1);
      end
    end
  end

  // Partial-word contents are never observable, so the shift register needs no reset.
  always_ff @(posedge clk) begin
    if (r_state == RX_SHIFT && bus.sample_en) r_shreg <= w_shift_next;
  end

  assign bus.data_out   = r_data_out;
  assign bus.word_ready = (r_state == RX_HANDOFF);
  assign bus.sclk_hold  = (r_state == RX_HANDOFF);
  assign bus.busy       = (r_state != RX_IDLE);
  assign bus.done       = r_done;
  assign bus.err        = r_err;

endmodule

// File: tb/tb_qspi_rx_shifter.sv
// Scoreboard bench for qspi_rx_shifter: expected words are queued as strobes are
// driven and compared when the shifter hands a word off.
module tb_qspi_rx_shifter;

  localparam int DATA_BITS = 32;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_pass;
  int   n_pushed;
  int   n_delivered;
  logic [31:0] exp_q[$];

  qspi_rx_shifter_if #(.DATA_BITS(DATA_BITS), .DUMMY_W(5), .WORDS_W(8)) bus ();

  qspi_rx_shifter #(.DATA_BITS(DATA_BITS), .DUMMY_W(5), .WORDS_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs === expv) n_pass++;
    else $display("FAIL %s observed=%h expected=%h", tag, obs, expv);
  endtask

  function automatic logic [31:0] exp_word(input logic [31:0] w);
`ifdef QSPI_RX_BYTE_SWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [1:0] mode, input logic [4:0] dummy, input logic [7:0] nw);
    bus.lane_mode    = mode;
    bus.dummy_cycles = dummy;
    bus.num_words    = nw;
    bus.start        = 1'b1;
    tick();
    bus.start        = 1'b0;
  endtask

  // Drive one word MSB-first on the lanes of the given mode; unused lanes carry noise.
  task automatic send_word(input logic [31:0] w, input logic [1:0] mode);
    int n;
    logic [3:0] r;
    exp_q.push_back(exp_word(w));
    n_pushed++;
    n = (mode == 2'b00) ? 32 : (mode == 2'b01) ? 16 : 8;
    for (int i = 0; i < n; i++) begin
      r = 4'($urandom);
      bus.sample_en = 1'b1;
      case (mode)
        2'b00:   bus.io_in = {r[3:2], w[31-i], r[0]};
        2'b01:   bus.io_in = {r[3:2], w[31-2*i], w[30-2*i]};
        default: bus.io_in = {w[31-4*i], w[30-4*i], w[29-4*i], w[28-4*i]};
      endcase
      tick();
    end
    bus.sample_en = 1'b0;
  endtask

  task automatic junk_strobes(input int n);
    for (int i = 0; i < n; i++) begin
      bus.sample_en = 1'b1;
      bus.io_in     = 4'($urandom);
      tick();
    end
    bus.sample_en = 1'b0;
  endtask

  // A handoff happens on the coming edge whenever word_ready=1 and sink_valid=0.
  always @(negedge clk) begin
    if (!reset && bus.word_ready && !bus.sink_valid) begin
      chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        chk("sb_word", bus.data_out, exp_q.pop_front());
        n_delivered++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    n_checks = 0; n_pass = 0; n_pushed = 0; n_delivered = 0;
    reset = 1'b1;
    bus.start = 1'b0; bus.abort = 1'b0; bus.lane_mode = 2'b00;
    bus.dummy_cycles = '0; bus.num_words = '0; bus.sample_en = 1'b0;
    bus.io_in = '0; bus.sink_valid = 1'b0;
    repeat (3) tick();
    chk("rst_data_out", bus.data_out, 32'h0);
    chk("rst_word_ready", 32'(bus.word_ready), 32'd0);
    chk("rst_sclk_hold", 32'(bus.sclk_hold), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    reset = 1'b0;
    tick();

    // Quad, no dummy, one word.
    do_start(2'b10, 5'd0, 8'd1);
    chk("q_busy_after_start", 32'(bus.busy), 32'd1);
    send_word(32'h1234_5678, 2'b10);
    chk("q_word_ready", 32'(bus.word_ready), 32'd1);
    chk("q_sclk_hold", 32'(bus.sclk_hold), 32'd1);
    chk("q_data_out", bus.data_out, exp_word(32'h1234_5678));
    tick();
    chk("q_word_ready_drop", 32'(bus.word_ready), 32'd0);
    chk("q_done", 32'(bus.done), 32'd1);
    chk("q_busy_at_done", 32'(bus.busy), 32'd0);

    // Single, 8 dummy strobes; started back-to-back in the done cycle.
    do_start(2'b00, 5'd8, 8'd1);
    chk("s_busy", 32'(bus.busy), 32'd1);
    chk("s_done_cleared", 32'(bus.done), 32'd0);
    junk_strobes(8);
    chk("s_no_ready_in_dummy", 32'(bus.word_ready), 32'd0);
    send_word(32'hA5A5_0F0F, 2'b00);
    chk("s_data_out", bus.data_out, exp_word(32'hA5A5_0F0F));
    tick();
    chk("s_done", 32'(bus.done), 32'd1);
    tick();
    chk("s_done_one_cycle", 32'(bus.done), 32'd0);

    // Dual, two words, sink busy for 5 cycles after the first word.
    do_start(2'b01, 5'd0, 8'd2);
    bus.sink_valid = 1'b1;
    send_word(32'hC3C3_9696, 2'b01);
    for (int i = 0; i < 5; i++) begin
      chk("d_wait_ready", 32'(bus.word_ready), 32'd1);
      chk("d_wait_hold", 32'(bus.sclk_hold), 32'd1);
      chk("d_wait_data", bus.data_out, exp_word(32'hC3C3_9696));
      bus.sample_en = 1'b1;
      bus.io_in     = 4'($urandom);
      tick();
    end
    bus.sample_en  = 1'b0;
    bus.sink_valid = 1'b0;
    tick();
    chk("d_ready_after_handoff", 32'(bus.word_ready), 32'd0);
    chk("d_busy_between_words", 32'(bus.busy), 32'd1);
    chk("d_no_early_done", 32'(bus.done), 32'd0);
    send_word(32'h0123_4567, 2'b01);
    chk("d_word2_ready", 32'(bus.word_ready), 32'd1);
    tick();
    chk("d_done", 32'(bus.done), 32'd1);
    tick();

    // Abort after 3 quad strobes.
    do_start(2'b10, 5'd0, 8'd1);
    junk_strobes(3);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("a_busy", 32'(bus.busy), 32'd0);
    chk("a_word_ready", 32'(bus.word_ready), 32'd0);
    chk("a_done", 32'(bus.done), 32'd0);
    chk("a_dout_hold", bus.data_out, exp_word(32'h0123_4567));
    tick();
    chk("a_done_late", 32'(bus.done), 32'd0);
    do_start(2'b10, 5'd0, 8'd1);
    send_word(32'hDEAD_BEEF, 2'b10);
    tick();
    chk("a_next_done", 32'(bus.done), 32'd1);

    // Illegal starts.
    do_start(2'b11, 5'd0, 8'd1);
    chk("e_mode_err", 32'(bus.err), 32'd1);
    chk("e_mode_busy", 32'(bus.busy), 32'd0);
    tick();
    chk("e_err_one_cycle", 32'(bus.err), 32'd0);
    do_start(2'b10, 5'd0, 8'd0);
    chk("e_nw_err", 32'(bus.err), 32'd1);
    chk("e_nw_busy", 32'(bus.busy), 32'd0);
    tick();

    // Reset mid-transfer discards the partial word.
    do_start(2'b10, 5'd2, 8'd1);
    junk_strobes(4);
    reset = 1'b1;
    #2;
    chk("r_busy", 32'(bus.busy), 32'd0);
    chk("r_data_out", bus.data_out, 32'h0);
    tick();
    reset = 1'b0;
    tick();
    do_start(2'b10, 5'd0, 8'd1);
    send_word(32'h8765_4321, 2'b10);
    tick();
    chk("r_next_done", 32'(bus.done), 32'd1);
    tick();

    chk("words_delivered", 32'(n_delivered), 32'(n_pushed));
    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/qspi_rx_shifter.md
# qspi_rx_shifter

Receive datapath of the QSPI controller. Samples the IO lanes on strobes from the SCLK generator, skips dummy cycles, and assembles 1/2/4-bit samples MSB-first into DATA_BITS words. It presents each completed word to the downstream read handshake stage and stalls SCLK until that stage has captured the word.

## Interface
- DATA_BITS, 32, receive word width; must be a multiple of 4.
- DUMMY_W, 5, width of the dummy-cycle count.
- WORDS_W, 8, width of the words-per-transfer count.

- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high.
- start  input  1  one-cycle pulse to begin a read; honoured in IDLE only.
- abort  input  1  synchronous abort; takes effect from any state.
- lane_mode  input  2  00 single (IO1), 01 dual (IO1:IO0), 10 quad (IO3:IO0), 11 illegal.
- dummy_cycles  input  DUMMY_W  sample strobes to discard before data.
- num_words  input  WORDS_W  words in this transfer; 0 is illegal.
- sample_en  input  1  one-cycle strobe at each SCLK sampling edge.
- io_in  input  4  synchronised QSPI IO lanes.
- sink_valid  input  1  downstream data_valid.
- data_out  output  DATA_BITS  completed word; stable while word_ready=1.
- word_ready  output  1  level; drives the downstream enable.
- sclk_hold  output  1  requests the SCLK generator to pause.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse after the last word is handed off.
- err  output  1  one-cycle pulse on an illegal start.

## Operation
- States: IDLE, DUMMY, SHIFT, HANDOFF.
- IDLE:
  - On start, latch lane_mode, dummy_cycles and num_words.
  - Go to DUMMY if dummy_cycles≠0, otherwise SHIFT.
  - If lane_mode=11 or num_words=0, stay in IDLE and pulse err.
- DUMMY: each sample_en decrements the dummy counter. When the counter reaches 0, go to SHIFT on that cycle.
- SHIFT: each sample_en performs shreg <= {shreg[DATA_BITS-bpw-1:0], lanes}.
  - bpw is 1, 2 or 4.
  - Lane order: IO1; IO1,IO0; IO3..IO0. The highest-numbered IO is the most significant bit of the sample.
  - The sample counter counts DATA_BITS/bpw strobes. On the last strobe, load data_out from the completed shift value and go to HANDOFF.
- HANDOFF:
  - word_ready=1 and sclk_hold=1.
  - A handoff occurs on any clk edge where word_ready=1 and sink_valid=0; the downstream stage captures data_out on that same edge.
  - After a handoff, decrement the words-remaining counter.
  - If words remain, go to SHIFT. No dummy cycles are inserted between words.
  - Otherwise go to IDLE and pulse done.
- sample_en is ignored in IDLE and HANDOFF.
- start is ignored outside IDLE.
- abort returns the block to IDLE on the next edge from any state.
  - Clears word_ready, sclk_hold and the counters.
  - data_out holds its last value.
  - No done pulse is generated.
  - abort takes priority over a simultaneous start or handoff.

## Timing
- Reset values: data_out=0, word_ready=0, sclk_hold=0, busy=0, done=0, err=0. State is IDLE.
- Reset mid-transfer behaves identically to the reset values above; any partial word is discarded.
- start to busy: busy rises 1 cycle after start.
- Last sample_en of a word to word_ready=1: 1 cycle.
- Handoff edge to word_ready=0: the same edge, so there is no double capture. In IDLE or SHIFT the next cycle shows word_ready=0.
- If sink_valid=1 when HANDOFF is entered, the block waits indefinitely. data_out and sclk_hold are held throughout.
- done pulses on the cycle after the final handoff edge, together with busy=0.
- Back-to-back: start is accepted on the cycle in which done is high.

## Configuration
- QSPI_RX_BYTE_SWAP_EN defined: data_out is loaded with the completed word byte-reversed (byte 0 ↔ byte N-1). This serves little-endian firmware.
- QSPI_RX_BYTE_SWAP_EN undefined: data_out equals the shift value unchanged.
- Shifting and handoff timing are identical in both builds.

## Structure
- Shared package qspi_pkg holds:
  - Lane-mode encodings LANE_SINGLE, LANE_DUAL, LANE_QUAD.
  - The rx state encoding.
  - The bits-per-sample function.
- One natural sub-module, qspi_rx_lane_mux: combinational selection of the sample bits and bpw from lane_mode.
- The FSM and counters stay in qspi_rx_shifter.

## Test plan
- Quad mode, dummy_cycles=0, num_words=1, 8 strobes with io_in=1,2,3,4,5,6,7,8, sink_valid=0 -> data_out=32'h12345678, word_ready high for exactly 1 cycle, done pulses the next cycle.
- Single mode, dummy_cycles=8, 40 strobes; the first 8 strobes drive junk and the remaining 32 drive IO1 with the bits of 32'hA5A5_0F0F -> data_out=32'hA5A50F0F and the junk is ignored.
- Dual mode, num_words=2, sink_valid=1 held for 5 cycles after the first word -> word_ready and sclk_hold stay high for 5 cycles, strobes are ignored during the wait, and both words are delivered in order.
- abort asserted mid-SHIFT after 3 quad strobes -> IDLE the next cycle, busy=0, no done pulse. A following transfer yields a correct word.
- lane_mode=11 with start, then num_words=0 with start -> err pulses each time, busy stays 0.
- With QSPI_RX_BYTE_SWAP_EN defined, repeat the first scenario -> data_out=32'h78563412.
